// File: rtl/stdio_pkg.sv
// Shared definitions for the memory-mapped stdio ports: FSM states,
// default register addresses and status-word bit positions.
package stdio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] STDIN_ADDR_DATA = 32'hFFFF_0010;
  localparam logic [31:0] STDIN_ADDR_STAT = 32'hFFFF_0014;
  localparam logic [31:0] STDIN_ADDR_PEEK = 32'hFFFF_0018;

  // Status word layout, also used by the stdout port.
  localparam int STAT_UNDERRUN  = 31;
  localparam int STAT_EXHAUSTED = 30;
  localparam int STAT_EMPTY     = 29;
  localparam int STAT_FULL      = 28;
  localparam int STAT_COUNT_W   = 8;

  function automatic logic [31:0] pack_status(
    input logic                    underrun,
    input logic                    exhausted,
    input logic                    empty,
    input logic                    full,
    input logic [STAT_COUNT_W-1:0] count
  );
    logic [31:0] word;
    word                 = '0;
    word[STAT_UNDERRUN]  = underrun;
    word[STAT_EXHAUSTED] = exhausted;
    word[STAT_EMPTY]     = empty;
    word[STAT_FULL]      = full;
    word[STAT_COUNT_W-1:0] = count;
    return word;
  endfunction

endpackage

// File: rtl/stdin_fifo.sv
// Synchronous prefetch FIFO for the stdin port. A push while full is
// accepted when a pop happens in the same cycle; head_o is the pre-edge head.
module stdin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  output logic [31:0]              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/stdin_port.sv
// CPU-side stdin port: prefetches source words into a FIFO and serves
// data/status loads. Optional non-popping peek address: STDIN_PEEK_EN.
module stdin_port
  import stdio_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_DATA = STDIN_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT = STDIN_ADDR_STAT,
  parameter logic [31:0] ADDR_PEEK = STDIN_ADDR_PEEK,
  parameter int          SRC_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] src_data_i,
  output logic        src_read_o,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_re_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_rvalid_o,
  output logic        bus_stall_o
);

`ifdef STDIN_PEEK_EN
  localparam logic PEEK_EN = 1'b1;
`else
  localparam logic PEEK_EN = 1'b0;
`endif

  localparam logic [8:0] LAST_WORD = 9'(SRC_WORDS - 1);

  state_t                 state_q, state_d;
  logic                   pop;
  logic                   load_rdata;
  logic [31:0]            rdata_d;
  logic                   set_underrun;
  logic                   fifo_full, fifo_empty;
  logic [31:0]            fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [8:0]             fetched_cnt;
  logic                   exhausted_q;
  logic                   underrun_q;
  logic [31:0]            consumed_cnt;
  logic                   hit_data, hit_stat, hit_peek;
  logic [31:0]            status_word;

  assign hit_data = bus_re_i && (bus_addr_i == ADDR_DATA);
  assign hit_stat = bus_re_i && (bus_addr_i == ADDR_STAT);
  assign hit_peek = PEEK_EN && bus_re_i && (bus_addr_i == ADDR_PEEK);

  // Refill into the slot freed by this cycle's pop; stop for good once the source is drained.
  assign src_read_o = !(fifo_full && !pop) && !exhausted_q && !reset_i;

  assign status_word = pack_status(underrun_q, exhausted_q, fifo_empty, fifo_full,
                                   STAT_COUNT_W'(fifo_count));

  stdin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (src_read_o),
    .push_data_i (src_data_i),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load_rdata   = 1'b0;
    rdata_d      = '0;
    set_underrun = 1'b0;
    bus_stall_o  = 1'b0;
    bus_rvalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_data) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load_rdata = 1'b1;
            rdata_d    = fifo_head;
            state_d    = RESP;
          end else begin
            state_d = WAIT;
          end
        end else if (hit_stat) begin
          load_rdata = 1'b1;
          rdata_d    = status_word;
          state_d    = RESP;
        end else if (hit_peek) begin
          load_rdata = 1'b1;
          rdata_d    = fifo_empty ? 32'h0 : fifo_head;
          state_d    = RESP;
        end
      end
      WAIT: begin
        bus_stall_o = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          load_rdata = 1'b1;
          rdata_d    = fifo_head;
          state_d    = RESP;
        end else if (exhausted_q) begin
          load_rdata   = 1'b1;
          set_underrun = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        bus_rvalid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      bus_rdata_o  <= '0;
      fetched_cnt  <= '0;
      exhausted_q  <= 1'b0;
      underrun_q   <= 1'b0;
      consumed_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load_rdata) bus_rdata_o <= rdata_d;
      if (src_read_o) begin
        fetched_cnt <= fetched_cnt + 9'd1;
        if (fetched_cnt == LAST_WORD) exhausted_q <= 1'b1;
      end
      if (set_underrun) underrun_q <= 1'b1;
      if (pop && !fifo_empty) consumed_cnt <= consumed_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stdin_port.sv
// Directed bench for stdin_port with a counting-source model and an
// expected-response queue; peek checks follow STDIN_PEEK_EN.
module tb_stdin_port;
  import stdio_pkg::*;

  // A short source keeps the exhaustion path reachable in a few cycles.
  localparam int TB_DEPTH     = 4;
  localparam int TB_SRC_WORDS = 6;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] src_data_i;
  logic        src_read_o;
  logic [31:0] bus_addr_i = '0;
  logic        bus_re_i = 1'b0;
  logic [31:0] bus_rdata_o;
  logic        bus_rvalid_o;
  logic        bus_stall_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_ptr;
  int          src_pulses;

  stdin_port #(
    .DEPTH     (TB_DEPTH),
    .SRC_WORDS (TB_SRC_WORDS)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .src_data_i   (src_data_i),
    .src_read_o   (src_read_o),
    .bus_addr_i   (bus_addr_i),
    .bus_re_i     (bus_re_i),
    .bus_rdata_o  (bus_rdata_o),
    .bus_rvalid_o (bus_rvalid_o),
    .bus_stall_o  (bus_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Source model: yields 1,2,3,... and is reloaded by the system reset.
  assign src_data_i = src_ptr + 32'd1;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_ptr    <= '0;
      src_pulses <= 0;
    end else if (src_read_o) begin
      src_ptr    <= src_ptr + 32'd1;
      src_pulses <= src_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    bus_re_i   = 1'b0;
    bus_addr_i = '0;
    reset_i    = 1'b1;
    @(posedge clk_i); #1;
    check("rst rdata",    bus_rdata_o,         32'h0);
    check("rst rvalid",   32'(bus_rvalid_o),   32'd0);
    check("rst stall",    32'(bus_stall_o),    32'd0);
    check("rst src_read", 32'(src_read_o),     32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("post-rst src_read", 32'(src_read_o), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issue one load, wait (bounded) for rvalid, compare against the queued expectation.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_lat, input int exp_stalls);
    int   lat;
    int   stalls;
    logic got;
    lat    = 0;
    stalls = 0;
    got    = 1'b0;
    exp_q.push_back(exp);
    bus_addr_i = addr;
    bus_re_i   = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (bus_rvalid_o) got = 1'b1;
      else if (bus_stall_o) stalls++;
    end
    check({tag, " rvalid"}, 32'(bus_rvalid_o), 32'd1);
    check({tag, " data"},   bus_rdata_o,       exp_q.pop_front());
    check({tag, " latency"}, 32'(lat),         32'(exp_lat));
    check({tag, " stalls"},  32'(stalls),      32'(exp_stalls));
    bus_re_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, " rvalid drops"}, 32'(bus_rvalid_o), 32'd0);
  endtask

  // Hold a request at an address that must be ignored and watch for any reaction.
  task automatic ignored_read(input string tag, input logic [31:0] addr);
    logic reacted;
    reacted    = 1'b0;
    bus_addr_i = addr;
    bus_re_i   = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (bus_rvalid_o || bus_stall_o) reacted = 1'b1;
    end
    bus_re_i = 1'b0;
    check({tag, " ignored"}, 32'(reacted), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    // Buffered reads after a warm-up.
    apply_reset();
    idle_cycles(8);
    do_read("rd1", STDIN_ADDR_DATA, 32'd1, 1, 0);
    do_read("rd2", STDIN_ADDR_DATA, 32'd2, 1, 0);
    do_read("rd3", STDIN_ADDR_DATA, 32'd3, 1, 0);
    check("consumed after 3", dut.consumed_cnt, 32'd3);
    ignored_read("unmapped", 32'hFFFF_001C);
    check("consumed after unmapped", dut.consumed_cnt, 32'd3);

    // Full FIFO status, no pops.
    apply_reset();
    idle_cycles(8);
    check("src_read while full", 32'(src_read_o), 32'd0);
    check("pulses at full", 32'(src_pulses), 32'd4);
    do_read("stat full", STDIN_ADDR_STAT, 32'h1000_0004, 1, 0);

    // Read in the first cycle after reset: one stall cycle.
    apply_reset();
    do_read("cold", STDIN_ADDR_DATA, 32'd1, 2, 1);

    // Drain a 6-word source, then underrun.
    apply_reset();
    idle_cycles(8);
    for (int w = 1; w <= TB_SRC_WORDS; w++)
      do_read($sformatf("drain%0d", w), STDIN_ADDR_DATA, 32'(w), 1, 0);
    do_read("underrun", STDIN_ADDR_DATA, 32'h0, 2, 1);
    do_read("stat underrun", STDIN_ADDR_STAT, 32'hE000_0000, 1, 0);
    check("pulses total", 32'(src_pulses), 32'(TB_SRC_WORDS));
    check("consumed drained", dut.consumed_cnt, 32'(TB_SRC_WORDS));

    // Reset while stalled in WAIT.
    apply_reset();
    bus_addr_i = STDIN_ADDR_DATA;
    bus_re_i   = 1'b1;
    @(posedge clk_i); #1;
    check("in wait stall", 32'(bus_stall_o), 32'd1);
    reset_i = 1'b1;
    bus_re_i = 1'b0;
    #1;
    check("wait-rst rdata",    bus_rdata_o,       32'h0);
    check("wait-rst rvalid",   32'(bus_rvalid_o), 32'd0);
    check("wait-rst stall",    32'(bus_stall_o),  32'd0);
    check("wait-rst src_read", 32'(src_read_o),   32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("refill restarts", 32'(src_read_o), 32'd1);
    ignored_read("no stale resp", 32'h0000_0000);
    check("refilled", 32'(src_pulses), 32'd4);
    check("consumed after wait-rst", dut.consumed_cnt, 32'd0);

    // Peek address: non-popping read when enabled, ignored otherwise.
    apply_reset();
    idle_cycles(8);
`ifdef STDIN_PEEK_EN
    do_read("peek1", STDIN_ADDR_PEEK, 32'd1, 1, 0);
    do_read("peek2", STDIN_ADDR_PEEK, 32'd1, 1, 0);
    do_read("pop after peek", STDIN_ADDR_DATA, 32'd1, 1, 0);
    check("consumed after peeks", dut.consumed_cnt, 32'd1);
    check("one refill after peeks", 32'(src_pulses), 32'd5);
`else
    ignored_read("peek disabled", STDIN_ADDR_PEEK);
    check("consumed peek disabled", dut.consumed_cnt, 32'd0);
    do_read("pop after peek", STDIN_ADDR_DATA, 32'd1, 1, 0);
`endif

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/stdin_port.md
# stdin_port

Memory-mapped CPU-side consumer of the simulation standard-input source. It prefetches words from the stdin source into a small FIFO by pulsing the source's read strobe, one word per cycle. It then serves CPU load requests to a data address and a status address with a registered single-cycle response, stalling when no data is buffered. It sits between the stdin source (upstream) and the core's data-bus I/O decoder (downstream).

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- ADDR_DATA, 32'hFFFF_0010: pop-read address.
- ADDR_STAT, 32'hFFFF_0014: status-read address.
- ADDR_PEEK, 32'hFFFF_0018: non-popping read address; decoded only with STDIN_PEEK_EN.
- SRC_WORDS, 256: total words the source can supply; equals the source pointer range.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- src_data_i  in  32  current word from the stdin source, combinational from its pointer.
- src_read_o  out  1  advance-pointer strobe to the source; combinational.
- bus_addr_i  in  32  load address.
- bus_re_i  in  1  load request; qualified by address decode.
- bus_rdata_o  out  32  registered load data.
- bus_rvalid_o  out  1  one-cycle response strobe.
- bus_stall_o  out  1  high while a request waits for data; the CPU holds address and re.

## Operation
- Fill: src_read_o = !full_next && !exhausted && !reset_i.
  - full_next is the FIFO-full condition after this cycle's pop.
  - On each edge with src_read_o high, src_data_i is pushed and fetched_cnt increments.
- fetched_cnt is 9 bits. When it reaches SRC_WORDS, exhausted is set sticky until reset. This prevents source pointer wrap.
- FSM states:
  - IDLE: on a hit to ADDR_DATA, pop and go to RESP if not empty; otherwise go to WAIT.
  - WAIT: bus_stall_o=1. When not empty, pop and go to RESP. If exhausted and empty, go to RESP returning 32'h0 and set the underrun flag.
  - RESP: bus_rvalid_o=1 for exactly one cycle, then go to IDLE. A new request in RESP is accepted next cycle, not in RESP itself.
- Hit to ADDR_STAT: IDLE→RESP with no pop. Data is {underrun, exhausted, empty, full, 20'b0, count[7:0]}.
- Requests to unmatched addresses are ignored; the state stays IDLE.
- Simultaneous push and pop: both occur and the count is unchanged. Pop data is the pre-edge head, never the word being pushed.
- consumed_cnt, 32 bits, counts pops. It is visible only through hierarchy, for the bench.
- Reset mid-operation: the FSM returns to IDLE and the FIFO empties. Counters and flags are cleared and no response is issued. The source pointer is not rewound; the team's system reset reloads the source.

## Timing
- Reset values: bus_rdata_o=0, bus_rvalid_o=0, bus_stall_o=0. src_read_o=0 during reset and 1 in the first cycle after reset.
- Cold start: the first word is in the FIFO 1 cycle after reset deassert. The FIFO is full after DEPTH cycles.
- Load latency with data buffered: request at edge N produces bus_rvalid_o high in cycle N+1, with data stable in that cycle.
- From empty: response arrives 2 cycles after the first push becomes visible.
- Back-to-back reads sustain one response every 2 cycles.

## Configuration
- STDIN_PEEK_EN defined: ADDR_PEEK decodes like ADDR_DATA without popping. If empty, it returns 32'h0 immediately, with no WAIT and no underrun.
- STDIN_PEEK_EN undefined: ADDR_PEEK is an unmatched address and is ignored.

## Structure
- Shared package stdio_pkg holds:
  - state_t enum {IDLE, WAIT, RESP}.
  - Default address constants.
  - Status bit-position localparams, shared with the future stdout port.
- One sub-module: stdin_fifo. It is a synchronous FIFO with push/pop/full/empty/count, parameterized by DEPTH.
- All FSM and decode logic lives in stdin_port.

## Test plan
- Source yields 1,2,3,…; reset, wait 8 cycles, read ADDR_DATA 3 times → responses 1,2,3 at 1 cycle each, consumed_cnt=3.
- Wait for FIFO full, then read ADDR_STAT → count=4, full=1, empty=0, exhausted=0.
- Read ADDR_DATA in the first cycle after reset → bus_stall_o high 1 cycle, then rvalid with data 1.
- SRC_WORDS=6, consume 6 words, read ADDR_DATA → stall, then data 0 with underrun=1 in subsequent STAT read. src_read_o pulses exactly 6 times in total.
- Assert reset_i during WAIT → no rvalid, all outputs 0, refill restarts the next cycle.
- With STDIN_PEEK_EN: peek twice, then pop → all three return the same word, and count drops by 1 only.
